self_trig_tagger: RTL and testbench
===================================

Name: self_trig_tagger

Overview:
- Receiving end of the end-of-column self-trigger line. Turns each accepted SelfTrigger pulse into a burst of 1–16 consecutive trigger strobes for the trigger/latency path.
- Assigns a rolling trigger tag to every strobe and buffers the tags in a FIFO for the readout logic.
- Applies programmable dead time after each burst and counts self-triggers it drops.

Parameters:
- FIFO_DEPTH, 32, tag FIFO depth; power of 2, minimum 16.
- TAG_W, 5, trigger tag width; the tag counter wraps modulo 2^TAG_W.

Ports:
- Clk40  input  1  40 MHz clock.
- Reset_b  input  1  asynchronous active-low reset.
- SelfTrigger  input  1  self-trigger line, synchronous to Clk40; may stay high for several cycles.
- SelfTrigEn  input  1  enables acceptance of new self-triggers.
- TrigMult  input  4  burst length minus 1 (0 gives 1 strobe, 15 gives 16 strobes).
- DeadTime  input  8  idle cycles after a burst before the next accept.
- ClearCnt  input  1  synchronous clear of MissedCnt.
- Trigger  output  1  trigger strobe, one per BX of the burst.
- TagValid  output  1  FIFO not empty.
- TagData  output  TAG_W  tag at the FIFO head.
- TagRead  input  1  pops the FIFO head when TagValid is 1.
- Busy  output  1  high when the FSM is not in IDLE.
- MissedCnt  output  8  dropped self-triggers; saturates at 255.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - Trigger=0, TagValid=0, TagData=0, Busy=0, MissedCnt=0.
  - Tag counter=0, FIFO pointers=0, edge register=0.
- Edge detect:
  - The block registers SelfTrigger once per cycle.
  - rise = SelfTrigger & ~SelfTrigger_q. Only rising edges count.
- Accept condition, evaluated in IDLE on rise:
  - SelfTrigEn=1, and
  - FIFO free entries ≥ TrigMult+1, with free space computed including any pop in the same cycle.
- IDLE:
  - rise and accept: latch TrigMult into the burst counter and go to BURST.
  - rise and not accept, with SelfTrigEn=1: MissedCnt++ (saturating). Stay in IDLE.
  - rise with SelfTrigEn=0: ignored, not counted.
- BURST:
  - Trigger=1 every cycle in this state.
  - Each cycle: push the current tag into the FIFO, increment the tag counter (wraps), decrement the burst counter.
  - When the burst counter reaches 0: go to DEAD if DeadTime≠0, otherwise go to IDLE.
  - Latency: rise sampled on edge N gives Trigger high in cycles N+1 … N+1+TrigMult.
- DEAD:
  - Load DeadTime on entry, count down, return to IDLE after exactly DeadTime cycles.
  - The first IDLE cycle can accept a new trigger.
- Busy:
  - A rise in BURST or DEAD with SelfTrigEn=1 increments MissedCnt.
  - TrigMult and DeadTime changes take effect only at the next accept.
  - SelfTrigEn falling mid-burst does not abort: the burst and dead time complete.
- FIFO:
  - First-word-fall-through: TagData is valid whenever TagValid=1.
  - Push and pop in the same cycle are allowed, including when full (the pop frees the slot) and when empty with a push (no pop; data appears the next cycle).
  - The acceptance check guarantees no overflow.
  - TagRead while empty is ignored.
- MissedCnt:
  - ClearCnt has priority over a simultaneous increment; the result is 0.
  - Holds at 255.
- Tags remain strictly sequential mod 2^TAG_W across bursts. Rejected triggers consume no tags.
- Reset asserted mid-burst: Trigger deasserts immediately (async) and the FIFO contents are discarded.

Test Plan:
- TrigMult=0, DeadTime=0, single SelfTrigger pulse at cycle 10, TagRead=1:
  - Trigger high in cycle 11 only.
  - TagValid from cycle 12 with TagData=0; the second trigger gets tag 1.
- TrigMult=3, DeadTime=4, SelfTrigger held high for 10 cycles:
  - Exactly 4 Trigger cycles, tags 0–3 queued.
  - One accept only (edge detect); MissedCnt=0.
  - Second pulse 1 cycle after DEAD ends is accepted; pulse during DEAD gives MissedCnt=1.
- TagRead=0, TrigMult=15, DEPTH=32:
  - Two bursts fill the FIFO (32 entries).
  - Third pulse rejected: no Trigger, MissedCnt=1.
  - Pop 16 entries, then a pulse is accepted and its tags continue from 0 (wrapped after 31).
- Full FIFO with TagRead=1 in the same cycle as rise and TrigMult=0: accepted, since free space counts the pop; no overflow, and order is preserved.
- Drive 300 rejected pulses:
  - MissedCnt holds at 255.
  - ClearCnt coincident with a reject leaves MissedCnt=0.
  - SelfTrigEn=0 pulses are not counted.
- Reset_b low mid-burst (TrigMult=7, cycle 3):
  - Trigger, TagValid, Busy all drop asynchronously.
  - After release, the first accepted trigger gets tag 0.

Source files
------------

// File: rtl/self_trig_tagger.sv
`timescale 1ns/1ps
// Tag FIFO (first-word-fall-through) and the self-trigger burst tagger that fills it.
// A self-trigger rise starts a burst of 1-16 tagged strobes, each tag queued for readout.

// Generic synchronous FIFO with first-word-fall-through head and an occupancy count.
// Latency: a pushed word appears at the head on the cycle after the push.
// Backpressure: a push is dropped when full unless a same-cycle pop frees the slot; a pop while empty is ignored.
module stt_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     Clk40,
    input  logic                     Reset_b,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop & (cnt != '0);
    assign do_push = push & ((cnt != FULL_CNT) | do_pop);

    always_ff @(posedge Clk40) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge Clk40 or negedge Reset_b) begin
        if (!Reset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (cnt == '0);
    assign count    = cnt;
endmodule

// Self-trigger receiver: rise on SelfTrigger -> burst of TrigMult+1 tagged strobes, then DeadTime idle cycles.
// Latency: rise sampled on edge N drives Trigger in cycles N+1 .. N+1+TrigMult; tags readable the cycle after their strobe.
// Backpressure: a burst is only accepted when the tag FIFO can hold all of it; otherwise the trigger is dropped and counted.
module self_trig_tagger #(
    parameter int FIFO_DEPTH = 32,
    parameter int TAG_W      = 5
) (
    input  logic             Clk40,
    input  logic             Reset_b,
    input  logic             SelfTrigger,
    input  logic             SelfTrigEn,
    input  logic [3:0]       TrigMult,
    input  logic [7:0]       DeadTime,
    input  logic             ClearCnt,
    output logic             Trigger,
    output logic             TagValid,
    output logic [TAG_W-1:0] TagData,
    input  logic             TagRead,
    output logic             Busy,
    output logic [7:0]       MissedCnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DEAD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             trig_q;
    logic             rise;
    logic [3:0]       burst_cnt;
    logic [7:0]       dead_len;
    logic [7:0]       dead_cnt;
    logic [TAG_W-1:0] tag_cnt;
    logic             tag_push;
    logic             tag_pop;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;
    logic [AW:0]      fifo_cnt;
    logic [AW:0]      free_cnt;
    logic [AW:0]      need_cnt;
    logic             space_ok;
    logic             accept;
    logic             miss;
    logic             burst_done;

    assign rise    = SelfTrigger & ~trig_q;
    assign tag_pop = TagRead & ~fifo_empty;

    // Free space counts a same-cycle pop so a full FIFO being read can still take a 1-strobe burst.
    assign free_cnt = FULL_CNT - fifo_cnt;
    assign need_cnt = (AW+1)'(TrigMult) + 1'b1;
    assign space_ok = (free_cnt + (AW+1)'(tag_pop)) >= need_cnt;

    assign accept     = (state == IDLE) & rise & SelfTrigEn & space_ok;
    assign miss       = rise & SelfTrigEn & ~accept;
    assign burst_done = (state == BURST) & (burst_cnt == 4'd0);

    always_ff @(posedge Clk40 or negedge Reset_b) begin
        if (!Reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = BURST;
            BURST:   if (burst_cnt == 4'd0) state_nxt = (dead_len != 8'd0) ? DEAD : IDLE;
            DEAD:    if (dead_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Trigger  = 1'b0;
        Busy     = 1'b0;
        tag_push = 1'b0;
        unique case (state)
            IDLE: ;
            BURST: begin
                Trigger  = 1'b1;
                Busy     = 1'b1;
                tag_push = 1'b1;
            end
            DEAD:    Busy = 1'b1;
            default: ;
        endcase
    end

    // Burst length and dead time are captured at accept so mid-burst register writes cannot disturb it.
    always_ff @(posedge Clk40 or negedge Reset_b) begin
        if (!Reset_b) begin
            trig_q    <= 1'b0;
            burst_cnt <= '0;
            dead_len  <= '0;
            dead_cnt  <= '0;
            tag_cnt   <= '0;
        end else begin
            trig_q <= SelfTrigger;
            if (accept) begin
                burst_cnt <= TrigMult;
                dead_len  <= DeadTime;
            end else if ((state == BURST) && (burst_cnt != 4'd0)) begin
                burst_cnt <= burst_cnt - 1'b1;
            end
            if (burst_done) begin
                dead_cnt <= dead_len - 1'b1;
            end else if ((state == DEAD) && (dead_cnt != 8'd0)) begin
                dead_cnt <= dead_cnt - 1'b1;
            end
            if (tag_push) begin
                tag_cnt <= tag_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk40 or negedge Reset_b) begin
        if (!Reset_b) begin
            MissedCnt <= '0;
        end else if (ClearCnt) begin
            MissedCnt <= '0;
        end else if (miss && (MissedCnt != 8'hFF)) begin
            MissedCnt <= MissedCnt + 1'b1;
        end
    end

    stt_fifo #(
        .W     (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .Clk40    (Clk40),
        .Reset_b  (Reset_b),
        .push     (tag_push),
        .push_dat (tag_cnt),
        .pop      (tag_pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    assign TagValid = ~fifo_empty;
    assign TagData  = TagValid ? fifo_head : '0;
endmodule

// File: tb/tb_self_trig_tagger.sv
`timescale 1ns/1ps
// Bench for self_trig_tagger: table of single-pulse configurations plus hand-written corner sequences,
// with a tag scoreboard fed when bursts are expected and drained whenever the bench pops the FIFO.
module tb_self_trig_tagger;
    localparam int TAG_W = 5;
    localparam int DEPTH = 32;

    logic             Clk40       = 1'b0;
    logic             Reset_b     = 1'b0;
    logic             SelfTrigger = 1'b0;
    logic             SelfTrigEn  = 1'b0;
    logic [3:0]       TrigMult    = 4'd0;
    logic [7:0]       DeadTime    = 8'd0;
    logic             ClearCnt    = 1'b0;
    logic             TagRead     = 1'b0;
    logic             Trigger;
    logic             TagValid;
    logic [TAG_W-1:0] TagData;
    logic             Busy;
    logic [7:0]       MissedCnt;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int exp_tag  = 0;
    int trig_cnt = 0;
    int busy_cnt = 0;
    int m0       = 0;

    typedef struct {
        logic       en;
        logic [3:0] mult;
        logic [7:0] dead;
        int         exp_trig;
        int         exp_miss;
        int         exp_busy;
    } vec_t;
    vec_t vecs[7];

    self_trig_tagger #(.FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .Clk40       (Clk40),
        .Reset_b     (Reset_b),
        .SelfTrigger (SelfTrigger),
        .SelfTrigEn  (SelfTrigEn),
        .TrigMult    (TrigMult),
        .DeadTime    (DeadTime),
        .ClearCnt    (ClearCnt),
        .Trigger     (Trigger),
        .TagValid    (TagValid),
        .TagData     (TagData),
        .TagRead     (TagRead),
        .Busy        (Busy),
        .MissedCnt   (MissedCnt)
    );

    always #12.5 Clk40 = ~Clk40;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Samples outputs mid-cycle, scores any pop that the coming edge performs, then advances one cycle.
    task automatic step();
        if (TagValid && TagRead) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tag_unexpected: got %0d expected none", TagData);
            end else begin
                chk("tag_order", int'(TagData), exp_q.pop_front());
            end
        end
        if (Trigger) trig_cnt++;
        if (Busy) busy_cnt++;
        @(posedge Clk40);
        #1;
    endtask

    task automatic expect_tags(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_tag);
            exp_tag = (exp_tag + 1) % (1 << TAG_W);
        end
    endtask

    task automatic pulse();
        SelfTrigger = 1'b1;
        step();
        SelfTrigger = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (Busy && n < max) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(Busy), 0);
    endtask

    task automatic reset_dut();
        Reset_b     = 1'b0;
        SelfTrigger = 1'b0;
        step();
        step();
        exp_q.delete();
        exp_tag = 0;
        Reset_b = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'd0,  8'd0, 1,  0, 1};
        vecs[1] = '{1'b1, 4'd3,  8'd4, 4,  0, 8};
        vecs[2] = '{1'b0, 4'd5,  8'd0, 0,  0, 0};
        vecs[3] = '{1'b1, 4'd15, 8'd2, 16, 0, 18};
        vecs[4] = '{1'b1, 4'd7,  8'd0, 8,  0, 8};
        vecs[5] = '{1'b1, 4'd1,  8'd1, 2,  0, 3};
        vecs[6] = '{1'b0, 4'd0,  8'd3, 0,  0, 0};

        // Reset state
        repeat (2) step();
        chk("rst_trigger",  int'(Trigger),   0);
        chk("rst_tagvalid", int'(TagValid),  0);
        chk("rst_tagdata",  int'(TagData),   0);
        chk("rst_busy",     int'(Busy),      0);
        chk("rst_missed",   int'(MissedCnt), 0);
        Reset_b = 1'b1;
        step();

        // Single strobe latency, first tag 0, second tag 1
        SelfTrigEn = 1'b1;
        TagRead    = 1'b1;
        repeat (8) step();
        expect_tags(1);
        SelfTrigger = 1'b1;
        step();
        chk("lat_trig_on", int'(Trigger), 1);
        chk("lat_busy_on", int'(Busy), 1);
        SelfTrigger = 1'b0;
        step();
        chk("lat_trig_off", int'(Trigger), 0);
        chk("lat_tagvalid", int'(TagValid), 1);
        chk("lat_tag0", int'(TagData), 0);
        expect_tags(1);
        pulse();
        wait_idle(40);
        repeat (3) step();
        chk("lat_sb_drained", exp_q.size(), 0);

        // Held SelfTrigger: one accept only
        TrigMult = 4'd3;
        DeadTime = 8'd4;
        m0 = int'(MissedCnt);
        trig_cnt = 0;
        busy_cnt = 0;
        expect_tags(4);
        SelfTrigger = 1'b1;
        repeat (10) step();
        SelfTrigger = 1'b0;
        step();
        wait_idle(50);
        chk("held_trig_cnt", trig_cnt, 4);
        chk("held_busy_cnt", busy_cnt, 8);
        chk("held_missed", int'(MissedCnt), m0);

        // Pulse during DEAD is missed, pulse in first IDLE cycle is accepted
        trig_cnt = 0;
        busy_cnt = 0;
        expect_tags(4);
        pulse();
        repeat (4) step();
        chk("dead_busy", int'(Busy), 1);
        SelfTrigger = 1'b1;
        step();
        SelfTrigger = 1'b0;
        chk("dead_missed", int'(MissedCnt), m0 + 1);
        wait_idle(20);
        expect_tags(4);
        SelfTrigger = 1'b1;
        step();
        chk("dead_first_idle_accept", int'(Trigger), 1);
        SelfTrigger = 1'b0;
        wait_idle(50);
        repeat (3) step();
        chk("dead_trig_cnt", trig_cnt, 8);
        chk("dead_busy_cnt", busy_cnt, 16);

        // Configuration table
        for (int i = 0; i < 7; i++) begin
            SelfTrigEn = vecs[i].en;
            TrigMult   = vecs[i].mult;
            DeadTime   = vecs[i].dead;
            m0 = int'(MissedCnt);
            trig_cnt = 0;
            busy_cnt = 0;
            if (vecs[i].exp_trig > 0) expect_tags(vecs[i].exp_trig);
            pulse();
            wait_idle(60);
            repeat (2) step();
            chk($sformatf("vec%0d_trig", i), trig_cnt, vecs[i].exp_trig);
            chk($sformatf("vec%0d_miss", i), int'(MissedCnt) - m0, vecs[i].exp_miss);
            chk($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
        end
        SelfTrigEn = 1'b1;
        chk("table_sb_drained", exp_q.size(), 0);

        // Fill FIFO, reject when full, pop 16, accept again with wrapped tags
        reset_dut();
        TagRead  = 1'b0;
        TrigMult = 4'd15;
        DeadTime = 8'd0;
        expect_tags(16);
        pulse();
        wait_idle(40);
        expect_tags(16);
        pulse();
        wait_idle(40);
        chk("full_tagvalid", int'(TagValid), 1);
        m0 = int'(MissedCnt);
        trig_cnt = 0;
        pulse();
        wait_idle(40);
        chk("full_reject_trig", trig_cnt, 0);
        chk("full_reject_missed", int'(MissedCnt), m0 + 1);
        TrigMult = 4'd0;
        pulse();
        chk("full_reject_m0_trig", trig_cnt, 0);
        chk("full_reject_m0_missed", int'(MissedCnt), m0 + 2);
        TagRead = 1'b1;
        repeat (16) step();
        TagRead  = 1'b0;
        TrigMult = 4'd15;
        trig_cnt = 0;
        expect_tags(16);
        pulse();
        wait_idle(40);
        chk("refill_trig", trig_cnt, 16);

        // Full FIFO with a pop coinciding with the rise: accepted
        m0 = int'(MissedCnt);
        TrigMult    = 4'd0;
        TagRead     = 1'b1;
        SelfTrigger = 1'b1;
        expect_tags(1);
        step();
        SelfTrigger = 1'b0;
        chk("fullpop_accept", int'(Trigger), 1);
        chk("fullpop_missed", int'(MissedCnt), m0);
        repeat (40) step();
        chk("fullpop_drained", int'(TagValid), 0);
        chk("fullpop_sb_empty", exp_q.size(), 0);

        // MissedCnt saturation, clear priority, disabled pulses not counted
        TagRead  = 1'b0;
        TrigMult = 4'd15;
        expect_tags(16);
        pulse();
        wait_idle(40);
        expect_tags(16);
        pulse();
        wait_idle(40);
        for (int i = 0; i < 300; i++) pulse();
        chk("sat_255", int'(MissedCnt), 255);
        ClearCnt    = 1'b1;
        SelfTrigger = 1'b1;
        step();
        ClearCnt    = 1'b0;
        SelfTrigger = 1'b0;
        chk("clear_priority", int'(MissedCnt), 0);
        step();
        SelfTrigEn = 1'b0;
        repeat (3) pulse();
        chk("disabled_not_counted", int'(MissedCnt), 0);
        SelfTrigEn = 1'b1;
        pulse();
        chk("count_after_clear", int'(MissedCnt), 1);
        TagRead = 1'b1;
        repeat (40) step();
        chk("sat_sb_empty", exp_q.size(), 0);

        // Async reset mid-burst, tags restart at 0
        TagRead     = 1'b0;
        TrigMult    = 4'd7;
        SelfTrigger = 1'b1;
        step();
        SelfTrigger = 1'b0;
        repeat (3) step();
        chk("midrst_pre_trig", int'(Trigger), 1);
        chk("midrst_pre_tagvalid", int'(TagValid), 1);
        #5;
        Reset_b = 1'b0;
        #1;
        chk("midrst_trigger", int'(Trigger), 0);
        chk("midrst_tagvalid", int'(TagValid), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_tagdata", int'(TagData), 0);
        exp_q.delete();
        exp_tag = 0;
        @(posedge Clk40);
        #1;
        Reset_b = 1'b1;
        step();
        TrigMult = 4'd0;
        TagRead  = 1'b1;
        expect_tags(1);
        pulse();
        chk("postrst_tagvalid", int'(TagValid), 1);
        chk("postrst_tag0", int'(TagData), 0);
        repeat (3) step();
        chk("postrst_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
